// File: rtl/m_prog_loader_if.sv
// ---------------------------------------------------------------------------
// m_prog_loader_if
// Byte-stream input and instruction-memory write bus of the program loader.
//
// Handshake: a byte moves from the source to the loader on a rising edge of
// w_clk when w_din_valid and w_din_ready are both high in that cycle. The
// source holds w_din stable while w_din_valid is high. w_din_ready never
// depends on w_din_valid, so there is no combinational path back to the source.
//
// Signals
//   w_din        byte from the source (e.g. UART receiver)
//   w_din_valid  w_din holds a valid byte this cycle
//   w_din_ready  loader can accept a byte this cycle
//   w_we         one-cycle instruction-memory write strobe
//   w_addr       instruction-memory word address
//   w_wdata      instruction-memory write data
//   w_ce         processor clock enable, high only after a complete load
//   w_err        sticky flag: header word count out of range
//
// Modports
//   master  byte source / memory side (drives w_din, w_din_valid)
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface m_prog_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        w_din;
    logic              w_din_valid;
    logic              w_din_ready;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_ce;
    logic              w_err;

    modport master (
        output w_din, w_din_valid,
        input  w_din_ready, w_we, w_addr, w_wdata, w_ce, w_err
    );

    modport slave (
        input  w_din, w_din_valid,
        output w_din_ready, w_we, w_addr, w_wdata, w_ce, w_err
    );
endinterface

// File: rtl/m_prog_loader.sv
// ---------------------------------------------------------------------------
// m_prog_loader
// Receives a program as a byte stream and writes it into instruction memory.
//
// The stream starts with a 4-byte little-endian word count N. It is followed
// by N little-endian 32-bit words. Word k is written to address k. When all N
// words are written, the processor clock enable w_ce goes high and stays high
// until reset. If N is larger than the memory depth, the loader parks in an
// error state with w_err high.
//
// Ports
//   w_clk        clock; all state changes on its rising edge
//   w_rst        asynchronous active-high reset
//   bus          m_prog_loader_if.slave (byte input + memory write bus)
//   w_dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module m_prog_loader #(
    parameter int ADDR_W = 12
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    m_prog_loader_if.slave        bus,
    output logic [2:0]            w_dbg_state
);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Largest legal word count: one full memory of 2^ADDR_W words.
    localparam logic [32:0] MAX_N = 33'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W:0]   idx_q;      // one extra bit so it can reach 2^ADDR_W
    logic [ADDR_W:0]   n_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;
    logic              din_ready;
    logic              accept;
    logic              last_byte;

    // Ready depends only on the state, never on w_din_valid.
    assign din_ready = (state_q == S_HDR) || (state_q == S_DATA);
    assign accept    = bus.w_din_valid & din_ready;
    assign last_byte = accept && (byte_cnt_q == 2'd3);

    // Bytes enter at the top and move down, so after four bytes the first
    // byte sits in bits 7:0 (little-endian).
    assign asm_next  = {bus.w_din, asm_q[31:8]};

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q    <= S_HDR;
            byte_cnt_q <= 2'd0;
            idx_q      <= '0;
            n_q        <= '0;
            asm_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                asm_q      <= asm_next;
                // Wraps from 3 to 0, which lines the counter up with the
                // next word.
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            // When N is out of range, the truncated value stored here is
            // never used, because the FSM goes to ERR.
            if (state_q == S_HDR && last_byte) begin
                n_q <= asm_next[ADDR_W:0];
            end
            if (state_q == S_WRITE) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // ---------------- next state and strobes ----------------
    always_comb begin
        state_d     = state_q;
        bus.w_we    = 1'b0;
        bus.w_ce    = 1'b0;
        bus.w_err   = 1'b0;
        unique case (state_q)
            S_HDR: begin
                if (last_byte) begin
                    if (asm_next == 32'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, asm_next} > MAX_N) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.w_we = 1'b1;
                // Compare against the post-increment index. With the extra
                // bit, N == 2^ADDR_W ends after address 2^ADDR_W-1 and does
                // not wrap.
                if (idx_q + 1'b1 == n_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                bus.w_ce = 1'b1;
            end
            S_ERR: begin
                bus.w_err = 1'b1;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    assign bus.w_din_ready = din_ready;
    assign bus.w_addr      = idx_q[ADDR_W-1:0];
    assign bus.w_wdata     = asm_q;
    assign w_dbg_state     = state_q;

endmodule

// File: tb/tb_m_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_m_prog_loader
// Drives program byte streams into m_prog_loader. Each stream is parsed by a
// simple reference model, which queues the expected (address, word) writes
// and predicts the final done/error status. Byte gaps are randomized.
// ---------------------------------------------------------------------------
module tb_m_prog_loader;

    localparam int AW    = 12;
    localparam int MAX_N = 1 << AW;
    localparam int BIG   = 1 << 30;

    // ---------------- clock / reset ----------------
    logic       w_clk = 1'b0;
    logic       w_rst = 1'b1;
    logic [2:0] w_dbg_state;

    always #5 w_clk = ~w_clk;

    m_prog_loader_if #(.ADDR_W(AW)) bus ();

    m_prog_loader #(.ADDR_W(AW)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .bus         (bus),
        .w_dbg_state (w_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [AW+31:0]   exp_q[$];     // {addr, data} of each expected write
    logic [7:0]       stim_q[$];    // bytes of the current stream
    bit               exp_done;
    bit               exp_err;
    int               last_addr = -1;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- write monitor ----------------
    always @(negedge w_clk) begin
        if (!w_rst) begin
            if (bus.w_we) begin
                if (exp_q.size() == 0) begin
                    check_val("we_unexpected", 1, 0);
                end else begin
                    logic [AW+31:0] e;
                    e = exp_q.pop_front();
                    check_val("wr_addr", bus.w_addr, e[AW+31:32]);
                    check_val("wr_data", bus.w_wdata, e[31:0]);
                    last_addr = int'(bus.w_addr);
                end
            end
            if (bus.w_ce) begin
                check_val("ce_pending", exp_q.size(), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            stim_q.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.w_din_valid = 1'b0;
        repeat (gap) begin
            bus.w_din = 8'($urandom);
            @(posedge w_clk); #1;
        end
        bus.w_din       = b;
        bus.w_din_valid = 1'b1;
        t = 0;
        while (!bus.w_din_ready && t < 16) begin
            @(posedge w_clk); #1;
            t++;
        end
        if (!bus.w_din_ready) check_val("ready_timeout", 0, 1);
        @(posedge w_clk); #1;
        bus.w_din_valid = 1'b0;
    endtask

    task automatic drive_junk(input int n);
        for (int i = 0; i < n; i++) begin
            bus.w_din       = 8'($urandom);
            bus.w_din_valid = 1'b1;
            @(posedge w_clk); #1;
        end
        bus.w_din_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2;
        w_rst = 1'b1;
        #1;
        check_val({tag, "_ready"}, bus.w_din_ready, 1);
        check_val({tag, "_we"},    bus.w_we,        0);
        check_val({tag, "_addr"},  bus.w_addr,      0);
        check_val({tag, "_wdata"}, bus.w_wdata,     0);
        check_val({tag, "_ce"},    bus.w_ce,        0);
        check_val({tag, "_err"},   bus.w_err,       0);
        @(posedge w_clk); #1;
        w_rst     = 1'b0;
        exp_q.delete();
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        last_addr = -1;
    endtask

    // Sends stim_q (up to 'limit' bytes) and, in the same pass, parses it the
    // way the stream format defines it: header N, then N words.
    task automatic run_stream(input int max_gap, input bit toggle, input int limit);
        logic [31:0] hdr;
        logic [31:0] word;
        int          di;
        int          gap;
        hdr  = 32'd0;
        word = 32'd0;
        for (int k = 0; k < stim_q.size() && k < limit; k++) begin
            if (exp_done || exp_err) break;
            gap = toggle ? ((k == 0) ? 0 : 1) : int'($urandom_range(0, max_gap));
            send_byte(stim_q[k], gap);
            if (k < 4) begin
                hdr = hdr | (32'(stim_q[k]) << (8 * k));
                if (k == 3) begin
                    if (hdr == 32'd0) begin
                        exp_done = 1'b1;
                        check_val("ce_after_hdr", bus.w_ce, 1);
                    end else if (hdr > 32'(MAX_N)) begin
                        exp_err = 1'b1;
                    end
                end
            end else begin
                di = k - 4;
                word[8*(di%4) +: 8] = stim_q[k];
                if (di % 4 == 3) begin
                    exp_q.push_back({AW'(di / 4), word});
                    if (32'(di / 4 + 1) == hdr) exp_done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_end(input string tag);
        repeat (2) begin @(posedge w_clk); #1; end
        check_val({tag, "_ce"},      bus.w_ce,        exp_done);
        check_val({tag, "_err"},     bus.w_err,       exp_err);
        check_val({tag, "_ready"},   bus.w_din_ready, !(exp_done || exp_err));
        check_val({tag, "_we"},      bus.w_we,        0);
        check_val({tag, "_pending"}, exp_q.size(),    0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.w_din       = 8'd0;
        bus.w_din_valid = 1'b0;
        repeat (2) @(posedge w_clk);
        #1;
        do_reset("rst0");

        // Two-instruction program
        stim_q.delete();
        push_word(32'd2);
        push_word(32'h0010_0513);
        push_word(32'h000F_0033);
        run_stream(0, 1'b0, BIG);
        check_end("prog2");
        check_val("prog2_last_addr", last_addr, 1);
        drive_junk(6);
        check_val("done_hold_ce", bus.w_ce, 1);

        // Empty program
        do_reset("rst1");
        stim_q.delete();
        push_word(32'd0);
        run_stream(2, 1'b0, BIG);
        check_end("n0");
        check_val("n0_no_write", last_addr, -1);

        // Word count one past the memory depth
        do_reset("rst2");
        stim_q.delete();
        push_word(32'd4097);
        run_stream(2, 1'b0, BIG);
        check_end("n4097");
        drive_junk(4);
        check_val("err_hold", bus.w_err, 1);
        check_val("err_hold_ce", bus.w_ce, 0);

        // Valid toggles every cycle
        do_reset("rst3");
        stim_q.delete();
        push_word(32'd1);
        push_word($urandom);
        run_stream(0, 1'b1, BIG);
        check_end("toggle");

        // Reset in the middle of word 1, then resend the whole stream
        do_reset("rst4");
        stim_q.delete();
        push_word(32'd2);
        push_word($urandom);
        push_word($urandom);
        run_stream(1, 1'b0, 10);
        do_reset("rst_mid");
        run_stream(1, 1'b0, BIG);
        check_end("after_mid_rst");
        check_val("after_mid_rst_last", last_addr, 1);

        // Random short programs with random gaps
        for (int r = 0; r < 6; r++) begin
            do_reset("rst_rand");
            stim_q.delete();
            n = int'($urandom_range(1, 9));
            push_word(32'(n));
            for (int i = 0; i < n; i++) push_word($urandom);
            run_stream(3, 1'b0, BIG);
            check_end("rand");
            check_val("rand_last_addr", last_addr, n - 1);
        end

        // Full memory, incrementing words
        do_reset("rst5");
        stim_q.delete();
        push_word(32'(MAX_N));
        n = int'($urandom);
        for (int i = 0; i < MAX_N; i++) push_word(32'(n + i));
        run_stream(0, 1'b0, BIG);
        check_end("full");
        check_val("full_last_addr", last_addr, MAX_N - 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
